// File: rtl/cordic_vector.sv
// Iterative 16-step CORDIC in vectoring mode: converts (x, y) to atan2 angle
// (Q3.29 radians) and gain-scaled magnitude, one micro-rotation per clock.
module cordic_vector (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic [31:0] angle_out,
  output logic [31:0] mag_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic signed [31:0] PI_HALF     = 32'sh3243F6A9;
  localparam logic signed [31:0] NEG_PI_HALF = 32'shCDBC0957;

  state_t             state;
  logic [3:0]         iter;
  logic signed [33:0] x, y;
  logic signed [31:0] z;
  logic               zero_vec;

  logic signed [33:0] x_ext, y_ext, x_sh, y_sh;
  logic signed [31:0] e;

  assign x_ext = {{2{x_in[31]}}, x_in};
  assign y_ext = {{2{y_in[31]}}, y_in};
  assign x_sh  = x >>> iter;
  assign y_sh  = y >>> iter;

  // atan(2^-i) scaled by 2^29
  always_comb begin
    case (iter)
      4'd0:    e = 32'sd421657428;
      4'd1:    e = 32'sd248918914;
      4'd2:    e = 32'sd131521918;
      4'd3:    e = 32'sd66762579;
      4'd4:    e = 32'sd33510843;
      4'd5:    e = 32'sd16771758;
      4'd6:    e = 32'sd8387925;
      4'd7:    e = 32'sd4194219;
      4'd8:    e = 32'sd2097141;
      4'd9:    e = 32'sd1048575;
      4'd10:   e = 32'sd524288;
      4'd11:   e = 32'sd262144;
      4'd12:   e = 32'sd131072;
      4'd13:   e = 32'sd65536;
      4'd14:   e = 32'sd32768;
      default: e = 32'sd16384;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      iter      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= 32'd0;
      mag_out   <= 32'd0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      zero_vec  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ITER;
            iter     <= 4'd0;
            busy     <= 1'b1;
            zero_vec <= (x_in == 32'd0) && (y_in == 32'd0);
            // Fold left half-plane into the right half so the CORDIC range covers it
            if (!x_in[31]) begin
              x <= x_ext;
              y <= y_ext;
              z <= 32'sd0;
            end else if (!y_in[31]) begin
              x <= y_ext;
              y <= -x_ext;
              z <= PI_HALF;
            end else begin
              x <= -y_ext;
              y <= x_ext;
              z <= NEG_PI_HALF;
            end
          end
        end
        ITER: begin
          // NOTE: non-blocking assignments make x and y both update from the old values.
          if (!y[33]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + e;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - e;
          end
          if (iter == 4'd15) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            iter <= iter + 4'd1;
          end
        end
        DONE: begin
          done      <= 1'b1;
          angle_out <= zero_vec ? 32'd0 : z;
          mag_out   <= zero_vec ? 32'd0 : x[31:0];
          iter      <= 4'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: hand-computed angle/magnitude vectors,
// latency, ignored re-start, reset abort and reset priority.
module tb_cordic_vector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] x_in, y_in;
  logic [31:0] angle_out, mag_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] P28 = 32'h1000_0000;
  localparam logic [31:0] N28 = 32'hF000_0000;
  localparam logic [31:0] P29 = 32'h2000_0000;
  localparam logic [31:0] N29 = 32'hE000_0000;
  localparam longint ATOL = 32768;

  cordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint actual, input longint expected,
                       input longint tol);
    longint diff;
    checks++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, actual, expected, tol);
    end
  endtask

  // Launch one request and watch 40 cycles; optionally re-pulse start at iteration repulse_at.
  task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input longint exp_a, input longint exp_m, input int repulse_at);
    int                 done_at;
    int                 done_cnt;
    logic signed [31:0] a_cap;
    logic        [31:0] m_cap;
    longint             tol_a, tol_m;
    done_at  = 0;
    done_cnt = 0;
    a_cap    = '0;
    m_cap    = '0;
    tol_a    = (exp_m == 0) ? 0 : ATOL;
    tol_m    = exp_m / 16384;
    @(posedge clk); #1;
    start = 1'b1; x_in = x; y_in = y;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, longint'(busy), 1, 0);
    for (int k = 1; k <= 40; k++) begin
      if (k - 1 == repulse_at) begin
        start = 1'b1; x_in = N29; y_in = N29;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 15) check({tag, "_busy_last_iter"}, longint'(busy), 1, 0);
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          a_cap   = angle_out;
          m_cap   = mag_out;
        end
      end
    end
    check({tag, "_done_at"}, done_at, 17, 0);
    check({tag, "_done_cnt"}, done_cnt, 1, 0);
    check({tag, "_angle"}, longint'(a_cap), exp_a, tol_a);
    check({tag, "_mag"}, longint'(m_cap), exp_m, tol_m);
    check({tag, "_angle_hold"}, longint'($signed(angle_out)), longint'(a_cap), 0);
    check({tag, "_mag_hold"}, longint'(mag_out), longint'(m_cap), 0);
    check({tag, "_busy_idle"}, longint'(busy), 0, 0);
  endtask

  initial begin
    int dcount;
    reset = 1'b0; start = 1'b0; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_angle", longint'(angle_out), 0, 0);
    check("rst_mag", longint'(mag_out), 0, 0);
    reset = 1'b1;

    run_vec("pos_x",   P28,   32'd0, 0,           442048841,  -1);
    run_vec("diag",    P28,   P28,   421657428,   625151466,  -1);
    run_vec("neg_x",   N28,   32'd0, 1686629713,  442048841,  -1);
    run_vec("neg_y",   32'd0, N28,   -843314857,  442048841,  -1);
    run_vec("q3",      N28,   N28,   -1264972285, 625151466,  -1);
    run_vec("zero",    32'd0, 32'd0, 0,           0,          -1);
    run_vec("q3_max",  N29,   N29,   -1264972285, 1250302932, -1);
    run_vec("q2_max",  N29,   P29,   1264972285,  1250302932, -1);
    run_vec("repulse", P28,   P28,   421657428,   625151466,  5);

    // Reset in the middle of iteration 8 aborts the request
    @(posedge clk); #1;
    start = 1'b1; x_in = P28; y_in = P28;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_busy", longint'(busy), 0, 0);
    check("abort_done", longint'(done), 0, 0);
    check("abort_angle", longint'(angle_out), 0, 0);
    check("abort_mag", longint'(mag_out), 0, 0);
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0, 0);
    run_vec("after_abort", P28, 32'd0, 0, 442048841, -1);

    // Reset wins over start on the same edge
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1; x_in = P28; y_in = P28;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    check("prio_busy0", longint'(busy), 0, 0);
    @(posedge clk); #1;
    check("prio_busy1", longint'(busy), 0, 0);
    run_vec("after_prio", P28, P28, 421657428, 625151466, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
